sram_ifc_param: RTL and testbench

//  Parametrised fabric-to-SRAM interface for one dual-port SRAM macro: port 0 writes, port 1 reads.

---
 rtl/sram_ifc_param.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sram_ifc_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ifc_param.sv
// sram_ifc_param
// Fabric-to-SRAM bridge for one dual-port macro (port 0 write, port 1 read).
// A logical word of 2^conf bits is packed into a DATA_W-bit physical row.
// The sub-address picks a lane of the row modulo the number of lanes. The
// lane bit offset is therefore (sub << Eff) truncated to SUB_AW bits.
// Every macro-facing signal is registered. A same-cycle write and read to
// the same row are resolved here by forwarding the written lane, so the
// macro's read-during-write result is never relied upon.
// Read latency is three cycles, or four cycles with out_reg set.
module sram_ifc_param #(
    parameter int DATA_W  = 32,
    parameter int BASE_AW = 9,
    parameter int SUB_AW  = 5,
    parameter int CONF_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         d_fabric_in,
    input  logic                      csb,
    input  logic                      web,
    input  logic                      reb,
    input  logic [BASE_AW+SUB_AW-1:0] addr_w,
    input  logic [BASE_AW+SUB_AW-1:0] addr_r,
    input  logic [CONF_W-1:0]         conf,
    input  logic                      out_reg,
    output logic [DATA_W-1:0]         d_sram_in,
    output logic [DATA_W-1:0]         w_mask,
    input  logic [DATA_W-1:0]         d_sram_out,
    output logic [DATA_W-1:0]         d_fabric_out,
    output logic                      rd_valid,
    output logic                      csb0_sync,
    output logic                      web0_sync,
    output logic                      csb1_sync,
    output logic [BASE_AW-1:0]        baseaddr_w_sync,
    output logic [BASE_AW-1:0]        baseaddr_r_sync
);

    localparam int AW    = BASE_AW + SUB_AW;
    localparam int EFF_W = $clog2(SUB_AW + 1);

    // Effective log2 word width: conf saturated at the full row width.
    function automatic logic [EFF_W-1:0] eff_of(input logic [CONF_W-1:0] c);
        logic [EFF_W-1:0] e;
        if (32'(c) > 32'(SUB_AW)) begin
            e = EFF_W'(SUB_AW);
        end else begin
            e = EFF_W'(c);
        end
        return e;
    endfunction

    // 2^e ones in the low bits of a row.
    function automatic logic [DATA_W-1:0] lane_ones(input logic [EFF_W-1:0] e);
        logic [DATA_W-1:0] ones;
        ones = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if ((i >> e) == 32'sd0) begin
                ones[i] = 1'b1;
            end else begin
                ones[i] = 1'b0;
            end
        end
        return ones;
    endfunction

    // Bit offset of the selected lane; truncation to SUB_AW bits wraps it.
    function automatic logic [SUB_AW-1:0] lane_offset(input logic [EFF_W-1:0] e,
                                                       input logic [SUB_AW-1:0] sub);
        logic [SUB_AW-1:0] off;
        off = sub << e;
        return off;
    endfunction

    // Per-bit write mask covering one lane.
    function automatic logic [DATA_W-1:0] mask_of(input logic [EFF_W-1:0] e,
                                                  input logic [SUB_AW-1:0] sub);
        return lane_ones(e) << lane_offset(e, sub);
    endfunction

    // Low 2^e bits of d replicated across the whole row.
    function automatic logic [DATA_W-1:0] replicate(input logic [EFF_W-1:0] e,
                                                    input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] rep;
        logic [SUB_AW-1:0] lm;
        lm  = SUB_AW'((32'd1 << e) - 32'd1);
        rep = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rep[i] = d[SUB_AW'(i) & lm];
        end
        return rep;
    endfunction

    // Selected lane of a row shifted down to bit 0, upper bits zero.
    function automatic logic [DATA_W-1:0] extract(input logic [EFF_W-1:0] e,
                                                  input logic [SUB_AW-1:0] sub,
                                                  input logic [DATA_W-1:0] row);
        return (row >> lane_offset(e, sub)) & lane_ones(e);
    endfunction

    // Request decode and stage-1 next-state values.
    logic              wr_s;
    logic              rd_s;
    logic [EFF_W-1:0]  eff_in_s;
    logic [DATA_W-1:0] w_mask_d;
    logic [DATA_W-1:0] d_sram_in_d;

    // Stage 1: macro-facing registers plus read-side context.
    logic              csb0_q;
    logic              web0_q;
    logic              csb1_q;
    logic [BASE_AW-1:0] base_w_q;
    logic [BASE_AW-1:0] base_r_q;
    logic [SUB_AW-1:0] sub_r_q;
    logic [EFF_W-1:0]  eff1_q;
    logic [DATA_W-1:0] w_mask_q;
    logic [DATA_W-1:0] d_sram_in_q;

    // Stage 2: context travelling with the read while the macro samples.
    logic              coll_d;
    logic              rd2_q;
    logic              coll2_q;
    logic [EFF_W-1:0]  eff2_q;
    logic [SUB_AW-1:0] sub2_q;
    logic [DATA_W-1:0] mask2_q;
    logic [DATA_W-1:0] din2_q;

    // Stage 3: captured macro output and merge context.
    logic              rd3_q;
    logic              coll3_q;
    logic [EFF_W-1:0]  eff3_q;
    logic [SUB_AW-1:0] sub3_q;
    logic [DATA_W-1:0] mask3_q;
    logic [DATA_W-1:0] din3_q;
    logic [DATA_W-1:0] dout3_q;
    logic [DATA_W-1:0] merged_s;
    logic [DATA_W-1:0] sel_s;

    // Optional output register stage.
    logic              rd_valid_q;
    logic [DATA_W-1:0] d_fabric_out_q;

    // Decode requests and precompute the mask and replicated data for stage 1.
    always_comb begin
        wr_s        = !csb && !web;
        rd_s        = !csb && !reb;
        eff_in_s    = eff_of(conf);
        w_mask_d    = mask_of(eff_in_s, addr_w[AW-1:BASE_AW]);
        d_sram_in_d = replicate(eff_in_s, d_fabric_in);
    end

    // Stage 1 registers: drive the macro pins and capture read context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            csb1_q      <= 1'b1;
            base_w_q    <= '0;
            base_r_q    <= '0;
            sub_r_q     <= '0;
            eff1_q      <= '0;
            w_mask_q    <= '0;
            d_sram_in_q <= '0;
        end else begin
            csb0_q      <= !wr_s;
            web0_q      <= web;
            csb1_q      <= !rd_s;
            base_w_q    <= addr_w[BASE_AW-1:0];
            base_r_q    <= addr_r[BASE_AW-1:0];
            sub_r_q     <= addr_r[AW-1:BASE_AW];
            eff1_q      <= eff_in_s;
            w_mask_q    <= w_mask_d;
            d_sram_in_q <= d_sram_in_d;
        end
    end

    // Collision: the macro is writing and reading the same row this cycle.
    always_comb begin
        coll_d = !csb0_q && !csb1_q && (base_w_q == base_r_q);
    end

    // Stage 2 registers: follow the read while the macro performs the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd2_q   <= 1'b0;
            coll2_q <= 1'b0;
            eff2_q  <= '0;
            sub2_q  <= '0;
            mask2_q <= '0;
            din2_q  <= '0;
        end else begin
            rd2_q   <= !csb1_q;
            coll2_q <= coll_d;
            eff2_q  <= eff1_q;
            sub2_q  <= sub_r_q;
            if (coll_d) begin
                mask2_q <= w_mask_q;
                din2_q  <= d_sram_in_q;
            end
        end
    end

    // Stage 3 registers: capture the macro read data with its context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd3_q   <= 1'b0;
            coll3_q <= 1'b0;
            eff3_q  <= '0;
            sub3_q  <= '0;
            mask3_q <= '0;
            din3_q  <= '0;
            dout3_q <= '0;
        end else begin
            rd3_q   <= rd2_q;
            coll3_q <= coll2_q;
            eff3_q  <= eff2_q;
            sub3_q  <= sub2_q;
            if (rd2_q) begin
                dout3_q <= d_sram_out;
            end
            if (coll2_q) begin
                mask3_q <= mask2_q;
                din3_q  <= din2_q;
            end
        end
    end

    // Overlay the colliding write lane onto the read row, then pick the lane.
    always_comb begin
        if (coll3_q) begin
            merged_s = (dout3_q & ~mask3_q) | (din3_q & mask3_q);
        end else begin
            merged_s = dout3_q;
        end
        sel_s = extract(eff3_q, sub3_q, merged_s);
    end

    // Output register stage: load only on a completed read so data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q     <= 1'b0;
            d_fabric_out_q <= '0;
        end else begin
            rd_valid_q <= rd3_q;
            if (rd3_q) begin
                d_fabric_out_q <= sel_s;
            end
        end
    end

    // Output select between the direct stage-3 decode and the extra register.
    always_comb begin
        if (out_reg) begin
            rd_valid     = rd_valid_q;
            d_fabric_out = d_fabric_out_q;
        end else begin
            rd_valid     = rd3_q;
            d_fabric_out = sel_s;
        end
    end

    // Macro-facing outputs come straight from stage-1 registers.
    always_comb begin
        csb0_sync       = csb0_q;
        web0_sync       = web0_q;
        csb1_sync       = csb1_q;
        baseaddr_w_sync = base_w_q;
        baseaddr_r_sync = base_r_q;
        w_mask          = w_mask_q;
        d_sram_in       = d_sram_in_q;
    end

endmodule

// File: tb/tb_sram_ifc_param.sv
// Testbench for sram_ifc_param: directed vectors, scoreboard of expected
// read results checked by a separate monitor, plus an SRAM macro model.
module tb_sram_ifc_param;

    localparam int DW  = 32;
    localparam int BAW = 9;
    localparam int SAW = 5;
    localparam int CW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    d_fabric_in;
    logic             csb, web, reb;
    logic [BAW+SAW-1:0] addr_w, addr_r;
    logic [CW-1:0]    conf;
    logic             out_reg;
    logic [DW-1:0]    d_sram_in, w_mask, d_sram_out, d_fabric_out;
    logic             rd_valid, csb0_sync, web0_sync, csb1_sync;
    logic [BAW-1:0]   baseaddr_w_sync, baseaddr_r_sync;

    sram_ifc_param #(.DATA_W(DW), .BASE_AW(BAW), .SUB_AW(SAW), .CONF_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .d_fabric_in(d_fabric_in),
        .csb(csb), .web(web), .reb(reb), .addr_w(addr_w), .addr_r(addr_r),
        .conf(conf), .out_reg(out_reg), .d_sram_in(d_sram_in), .w_mask(w_mask),
        .d_sram_out(d_sram_out), .d_fabric_out(d_fabric_out), .rd_valid(rd_valid),
        .csb0_sync(csb0_sync), .web0_sync(web0_sync), .csb1_sync(csb1_sync),
        .baseaddr_w_sync(baseaddr_w_sync), .baseaddr_r_sync(baseaddr_r_sync)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 32'd0;

    // Posedge counter used to time-stamp expected results.
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Macro model: masked write, registered read. On a same-row collision the
    // bits being written read back as garbage, so only forwarding can fix them.
    logic [DW-1:0] mem [0:(1<<BAW)-1];
    always @(posedge clk) begin
        if (!csb1_sync) begin
            if (!csb0_sync && !web0_sync && baseaddr_w_sync == baseaddr_r_sync)
                d_sram_out <= (mem[baseaddr_r_sync] & ~w_mask) | (32'hBAD0BAD0 & w_mask);
            else
                d_sram_out <= mem[baseaddr_r_sync];
        end
        if (!csb0_sync && !web0_sync)
            mem[baseaddr_w_sync] <= (mem[baseaddr_w_sync] & ~w_mask) | (d_sram_in & w_mask);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a read result.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_rd_valid: got none expected data %h due cycle %0d", sb_q[0].data, sb_q[0].due);
            e = sb_q.pop_front();
        end
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got data %h expected no result (cycle %0d)", d_fabric_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rd_data", d_fabric_out, e.data);
                check("rd_cycle", cyc, e.due);
            end
        end
    end

    // Drive one request cycle (called just after a negedge).
    task automatic op(input logic w, input logic r, input logic [2:0] cf,
                      input logic [4:0] sw, input logic [8:0] bw,
                      input logic [4:0] sr, input logic [8:0] br,
                      input logic [31:0] din, input logic [31:0] exp_v);
        csb         = !(w || r);
        web         = !w;
        reb         = !r;
        conf        = cf;
        addr_w      = {sw, bw};
        addr_r      = {sr, br};
        d_fabric_in = din;
        if (r) sb_q.push_back('{data: exp_v, due: cyc + 32'd3 + 32'(out_reg)});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        csb = 1'b1;
        web = 1'b1;
        reb = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; csb = 1'b1; web = 1'b1; reb = 1'b1; conf = 3'd0;
        addr_w = '0; addr_r = '0; d_fabric_in = 32'd0; out_reg = 1'b0;
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_csb0", 32'(csb0_sync), 32'd1);
        check("rst_web0", 32'(web0_sync), 32'd1);
        check("rst_csb1", 32'(csb1_sync), 32'd1);
        check("rst_mask", w_mask, 32'd0);
        check("rst_din", d_sram_in, 32'd0);
        check("rst_addr", 32'(baseaddr_r_sync), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_out", d_fabric_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-width write and read
        op(1'b1, 1'b0, 3'd5, 5'd0, 9'd3, 5'd0, 9'd0, 32'hDEADBEEF, 32'd0);
        check("c5_mask", w_mask, 32'hFFFFFFFF);
        check("c5_din", d_sram_in, 32'hDEADBEEF);
        check("wr_csb0", 32'(csb0_sync), 32'd0);
        check("wr_web0", 32'(web0_sync), 32'd0);
        check("wr_csb1", 32'(csb1_sync), 32'd1);
        check("wr_base", 32'(baseaddr_w_sync), 32'd3);
        op(1'b0, 1'b1, 3'd5, 5'd0, 9'd0, 5'd0, 9'd3, 32'd0, 32'hDEADBEEF);
        check("rd_csb1", 32'(csb1_sync), 32'd0);
        check("rd_csb0", 32'(csb0_sync), 32'd1);
        check("rd_base", 32'(baseaddr_r_sync), 32'd3);

        // Byte lanes, wrap-around of the sub address
        op(1'b1, 1'b0, 3'd5, 5'd0, 9'd4, 5'd0, 9'd0, 32'h12345678, 32'd0);
        op(1'b1, 1'b0, 3'd3, 5'd2, 9'd4, 5'd0, 9'd0, 32'hFFFFFFA5, 32'd0);
        check("c3_mask", w_mask, 32'h00FF0000);
        check("c3_din", d_sram_in, 32'hA5A5A5A5);
        op(1'b0, 1'b1, 3'd3, 5'd0, 9'd0, 5'd2, 9'd4, 32'd0, 32'h000000A5);
        op(1'b0, 1'b1, 3'd3, 5'd0, 9'd0, 5'd3, 9'd4, 32'd0, 32'h00000012);
        op(1'b0, 1'b1, 3'd3, 5'd0, 9'd0, 5'd6, 9'd4, 32'd0, 32'h000000A5);
        op(1'b0, 1'b1, 3'd3, 5'd0, 9'd0, 5'd22, 9'd4, 32'd0, 32'h000000A5);

        // Same-row collisions and a non-colliding write+read
        op(1'b1, 1'b0, 3'd5, 5'd0, 9'd5, 5'd0, 9'd0, 32'h11223344, 32'd0);
        op(1'b1, 1'b1, 3'd3, 5'd1, 9'd5, 5'd0, 9'd5, 32'h00000077, 32'h00000044);
        op(1'b1, 1'b1, 3'd3, 5'd2, 9'd5, 5'd2, 9'd5, 32'h000000EE, 32'h000000EE);
        op(1'b1, 1'b1, 3'd5, 5'd0, 9'd8, 5'd0, 9'd5, 32'h00000055, 32'h11EE7744);

        // Saturated conf and single-bit lanes
        op(1'b1, 1'b0, 3'd7, 5'd3, 9'd6, 5'd0, 9'd0, 32'hCAFEF00D, 32'd0);
        check("c7_mask", w_mask, 32'hFFFFFFFF);
        check("c7_din", d_sram_in, 32'hCAFEF00D);
        op(1'b0, 1'b1, 3'd7, 5'd0, 9'd0, 5'd9, 9'd6, 32'd0, 32'hCAFEF00D);
        op(1'b1, 1'b0, 3'd0, 5'd31, 9'd7, 5'd0, 9'd0, 32'h00000001, 32'd0);
        check("c0_mask", w_mask, 32'h80000000);
        check("c0_din", d_sram_in, 32'hFFFFFFFF);
        idle(5);

        // Reset in the middle of an outstanding read drops it
        op(1'b0, 1'b1, 3'd5, 5'd0, 9'd0, 5'd0, 9'd3, 32'd0, 32'hDEADBEEF);
        idle(0);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_csb0", 32'(csb0_sync), 32'd1);
        check("mid_rst_csb1", 32'(csb1_sync), 32'd1);
        check("mid_rst_web0", 32'(web0_sync), 32'd1);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        op(1'b0, 1'b1, 3'd5, 5'd0, 9'd0, 5'd0, 9'd3, 32'd0, 32'hDEADBEEF);
        idle(5);

        // Output register stage, back-to-back reads with alternating conf
        out_reg = 1'b1;
        @(negedge clk);
        op(1'b0, 1'b1, 3'd0, 5'd0, 9'd0, 5'd2, 9'd5, 32'd0, 32'h00000001);
        op(1'b0, 1'b1, 3'd5, 5'd0, 9'd0, 5'd0, 9'd5, 32'd0, 32'h11EE7744);
        op(1'b0, 1'b1, 3'd0, 5'd0, 9'd0, 5'd3, 9'd5, 32'd0, 32'h00000000);
        op(1'b0, 1'b1, 3'd5, 5'd0, 9'd0, 5'd0, 9'd3, 32'd0, 32'hDEADBEEF);
        idle(6);
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_out", d_fabric_out, 32'hDEADBEEF);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
